clock_set_ctrl: RTL and testbench

//  Button-driven setting controller for the digital alarm clock. It sequences the user through

---
 rtl/clock_set_ctrl_if.sv | 38 +++
 rtl/clock_set_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Front-panel / datapath bundle for the alarm-clock setting controller.
//   btn_mode/btn_set/btn_inc : debounced button levels into the controller
//   cur_h1/cur_h0/cur_m1/cur_m0 : live BCD clock time into the controller
//   H_in1/H_in0/M_in1/M_in0  : BCD set value out to the clock datapath
//   LD_time/LD_alarm         : load strobes out to the clock datapath
//   editing/edit_field/edit_target : edit status for the display
interface clock_set_ctrl_if;
    logic       btn_mode;
    logic       btn_set;
    logic       btn_inc;
    logic [1:0] cur_h1;
    logic [3:0] cur_h0;
    logic [2:0] cur_m1;
    logic [3:0] cur_m0;
    logic [1:0] H_in1;
    logic [3:0] H_in0;
    logic [2:0] M_in1;
    logic [3:0] M_in0;
    logic       LD_time;
    logic       LD_alarm;
    logic       editing;
    logic [1:0] edit_field;
    logic       edit_target;

    // panel / test side
    modport master (
        output btn_mode, btn_set, btn_inc, cur_h1, cur_h0, cur_m1, cur_m0,
        input  H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm,
               editing, edit_field, edit_target
    );

    // controller side
    modport slave (
        input  btn_mode, btn_set, btn_inc, cur_h1, cur_h0, cur_m1, cur_m0,
        output H_in1, H_in0, M_in1, M_in0, LD_time, LD_alarm,
               editing, edit_field, edit_target
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Button-driven time/alarm setting controller for the alarm clock.
// Walks the user through target select, hour edit and minute edit, then
// holds a load strobe for LD_HOLD cycles with the edited BCD value.
//   clk   : system clock
//   reset : asynchronous, active-high reset
//   bus   : buttons, live time in; set value, strobes and edit status out
module clock_set_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1000,
    parameter int unsigned REPEAT_CYC  = 50,
    parameter int unsigned LD_HOLD     = 10
) (
    input  logic             clk,
    input  logic             reset,
    clock_set_ctrl_if.slave  bus
);
    localparam int unsigned DWELL_MAX = (TIMEOUT_CYC > LD_HOLD) ? TIMEOUT_CYC : LD_HOLD;
    localparam int unsigned DWELL_W   = $clog2(DWELL_MAX + 1);
    localparam int unsigned REP_W     = $clog2(REPEAT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SEL      = 3'd1,
        S_EDIT_HR  = 3'd2,
        S_EDIT_MIN = 3'd3,
        S_COMMIT   = 3'd4
    } state_t;

    state_t             state_q, state_n;
    logic               mode_q, set_q, inc_q;
    logic               target_q, target_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [REP_W-1:0]   rep_q, rep_n;
    logic [1:0]         wk_h1_q, sh_h1_q;
    logic [3:0]         wk_h0_q, sh_h0_q;
    logic [2:0]         wk_m1_q, sh_m1_q;
    logic [3:0]         wk_m0_q, sh_m0_q;
    logic               ld_time_q, ld_alarm_q, editing_q, edit_target_q;
    logic [1:0]         edit_field_q;

    logic       mode_p, set_p, inc_p, inc_held, in_edit, activity, inc_step;
    logic       load_work, hr_inc, min_inc, commit_enter;
    logic [1:0] hr_h1_n;
    logic [3:0] hr_h0_n;
    logic [2:0] mn_m1_n;
    logic [3:0] mn_m0_n;

    // one-cycle press pulses; a level held through reset never pulses
    assign mode_p   = bus.btn_mode & ~mode_q;
    assign set_p    = bus.btn_set  & ~set_q;
    assign inc_p    = bus.btn_inc  & ~inc_q;
    assign inc_held = bus.btn_inc  & inc_q;
    assign in_edit  = (state_q == S_EDIT_HR) || (state_q == S_EDIT_MIN);
    assign activity = mode_p | set_p | inc_p | bus.btn_inc;
    assign inc_step = inc_p | (inc_held & in_edit & (rep_q == REP_W'(REPEAT_CYC)));

    // BCD hour increment with 23 -> 00 wrap
    always_comb begin
        hr_h1_n = wk_h1_q;
        hr_h0_n = wk_h0_q;
        if (wk_h1_q == 2'd2 && wk_h0_q == 4'd3) begin
            hr_h1_n = 2'd0;
            hr_h0_n = 4'd0;
        end else if (wk_h0_q == 4'd9) begin
            hr_h1_n = wk_h1_q + 2'd1;
            hr_h0_n = 4'd0;
        end else begin
            hr_h0_n = wk_h0_q + 4'd1;
        end
    end

    // BCD minute increment with 59 -> 00 wrap, no carry out
    always_comb begin
        mn_m1_n = wk_m1_q;
        mn_m0_n = wk_m0_q;
        if (wk_m0_q == 4'd9) begin
            mn_m0_n = 4'd0;
            mn_m1_n = (wk_m1_q == 3'd5) ? 3'd0 : wk_m1_q + 3'd1;
        end else begin
            mn_m0_n = wk_m0_q + 4'd1;
        end
    end

    // next-state and datapath controls; priority mode > set > inc
    always_comb begin
        state_n      = state_q;
        target_n     = target_q;
        load_work    = 1'b0;
        hr_inc       = 1'b0;
        min_inc      = 1'b0;
        commit_enter = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mode_p) begin
                    state_n  = S_SEL;
                    target_n = 1'b0;
                end
            end
            S_SEL: begin
                if (mode_p) begin
                    target_n = ~target_q;
                end else if (set_p) begin
                    state_n   = S_EDIT_HR;
                    load_work = 1'b1;
                end
            end
            S_EDIT_HR: begin
                if (mode_p)        state_n = S_IDLE;
                else if (set_p)    state_n = S_EDIT_MIN;
                else if (inc_step) hr_inc  = 1'b1;
            end
            S_EDIT_MIN: begin
                if (mode_p) begin
                    state_n = S_IDLE;
                end else if (set_p) begin
                    state_n      = S_COMMIT;
                    commit_enter = 1'b1;
                end else if (inc_step) begin
                    min_inc = 1'b1;
                end
            end
            S_COMMIT: begin
                if (dwell_q == DWELL_W'(LD_HOLD - 1)) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        // abandon an idle edit; any activity keeps dwell below the limit
        if ((state_q == S_SEL || in_edit) && !activity &&
            dwell_q == DWELL_W'(TIMEOUT_CYC - 1)) begin
            state_n = S_IDLE;
        end
    end

    // dwell counts time in state: idle time while editing, strobe time in COMMIT
    always_comb begin
        dwell_n = dwell_q;
        if (state_n != state_q)
            dwell_n = '0;
        else if (state_q != S_COMMIT && activity)
            dwell_n = '0;
        else if (dwell_q != DWELL_W'(DWELL_MAX))
            dwell_n = dwell_q + DWELL_W'(1);
    end

    // auto-repeat: counts held cycles since press, fires every REPEAT_CYC
    always_comb begin
        rep_n = '0;
        if (in_edit && inc_held && state_n == state_q) begin
            if (rep_q == REP_W'(REPEAT_CYC)) rep_n = REP_W'(1);
            else                             rep_n = rep_q + REP_W'(1);
        end
    end

    // state register and control counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b1;
            set_q    <= 1'b1;
            inc_q    <= 1'b1;
            target_q <= 1'b0;
            dwell_q  <= '0;
            rep_q    <= '0;
        end else begin
            state_q  <= state_n;
            mode_q   <= bus.btn_mode;
            set_q    <= bus.btn_set;
            inc_q    <= bus.btn_inc;
            target_q <= target_n;
            dwell_q  <= dwell_n;
            rep_q    <= rep_n;
        end
    end

    // working digits and alarm shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wk_h1_q <= '0; wk_h0_q <= '0; wk_m1_q <= '0; wk_m0_q <= '0;
            sh_h1_q <= '0; sh_h0_q <= '0; sh_m1_q <= '0; sh_m0_q <= '0;
        end else begin
            if (load_work) begin
                if (target_q) begin
                    wk_h1_q <= sh_h1_q; wk_h0_q <= sh_h0_q;
                    wk_m1_q <= sh_m1_q; wk_m0_q <= sh_m0_q;
                end else begin
                    wk_h1_q <= bus.cur_h1; wk_h0_q <= bus.cur_h0;
                    wk_m1_q <= bus.cur_m1; wk_m0_q <= bus.cur_m0;
                end
            end
            if (hr_inc) begin
                wk_h1_q <= hr_h1_n;
                wk_h0_q <= hr_h0_n;
            end
            if (min_inc) begin
                wk_m1_q <= mn_m1_n;
                wk_m0_q <= mn_m0_n;
            end
            if (commit_enter && target_q) begin
                sh_h1_q <= wk_h1_q; sh_h0_q <= wk_h0_q;
                sh_m1_q <= wk_m1_q; sh_m0_q <= wk_m0_q;
            end
        end
    end

    // status and strobe outputs, registered from next state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ld_time_q     <= 1'b0;
            ld_alarm_q    <= 1'b0;
            editing_q     <= 1'b0;
            edit_field_q  <= 2'd0;
            edit_target_q <= 1'b0;
        end else begin
            ld_time_q     <= (state_n == S_COMMIT) && !target_n;
            ld_alarm_q    <= (state_n == S_COMMIT) && target_n;
            editing_q     <= (state_n == S_SEL) || (state_n == S_EDIT_HR) ||
                             (state_n == S_EDIT_MIN);
            edit_field_q  <= (state_n == S_EDIT_HR)  ? 2'd1 :
                             (state_n == S_EDIT_MIN) ? 2'd2 : 2'd0;
            edit_target_q <= target_n;
        end
    end

    assign bus.H_in1       = wk_h1_q;
    assign bus.H_in0       = wk_h0_q;
    assign bus.M_in1       = wk_m1_q;
    assign bus.M_in0       = wk_m0_q;
    assign bus.LD_time     = ld_time_q;
    assign bus.LD_alarm    = ld_alarm_q;
    assign bus.editing     = editing_q;
    assign bus.edit_field  = edit_field_q;
    assign bus.edit_target = edit_target_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl: directed scenarios plus randomized
// edits checked against an arithmetic (hours mod 24, minutes mod 60) model.
module tb_clock_set_ctrl;
    localparam int unsigned TOUT = 1000;
    localparam int unsigned REP  = 50;
    localparam int unsigned HOLD = 10;

    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   ld_cycles;
    int   both_cycles;
    int   alarm_h;
    int   alarm_m;

    clock_set_ctrl_if bus();

    clock_set_ctrl #(.TIMEOUT_CYC(TOUT), .REPEAT_CYC(REP), .LD_HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // strobe activity seen at mid-cycle
    always @(negedge clk) begin
        if (bus.LD_time === 1'b1 || bus.LD_alarm === 1'b1) ld_cycles++;
        if (bus.LD_time === 1'b1 && bus.LD_alarm === 1'b1) both_cycles++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pack_hm(input int h, input int m);
        return 32'((h / 10) << 11 | (h % 10) << 7 | (m / 10) << 4 | (m % 10));
    endfunction

    function automatic logic [31:0] shown();
        return {19'd0, bus.H_in1, bus.H_in0, bus.M_in1, bus.M_in0};
    endfunction

    task automatic set_cur(input int h, input int m);
        bus.cur_h1 = 2'(h / 10);
        bus.cur_h0 = 4'(h % 10);
        bus.cur_m1 = 3'(m / 10);
        bus.cur_m0 = 4'(m % 10);
    endtask

    // which: 0 mode, 1 set, 2 inc
    task automatic press(input int which);
        if (which == 0) bus.btn_mode = 1'b1;
        if (which == 1) bus.btn_set  = 1'b1;
        if (which == 2) bus.btn_inc  = 1'b1;
        step(1);
        bus.btn_mode = 1'b0;
        bus.btn_set  = 1'b0;
        bus.btn_inc  = 1'b0;
        step(1);
    endtask

    // mode [mode] set -> EDIT_HR with seed check
    task automatic enter_hr(input int tgt, input int sh, input int sm, input string tag);
        press(0);
        if (tgt != 0) press(0);
        chk({tag, "_target"}, 32'(bus.edit_target), 32'(tgt));
        press(1);
        chk({tag, "_field_hr"}, 32'(bus.edit_field), 32'd1);
        chk({tag, "_seed"}, shown(), pack_hm(sh, sm));
    endtask

    // full edit and commit; model result is seed + increments, modulo field range
    task automatic do_edit(input int tgt, input int ch, input int cm, input int nh, input int nm,
                           input string tag);
        int sh, sm, eh, em, hi, other;
        sh = (tgt != 0) ? alarm_h : ch;
        sm = (tgt != 0) ? alarm_m : cm;
        set_cur(ch, cm);
        enter_hr(tgt, sh, sm, tag);
        for (int i = 0; i < nh; i++) press(2);
        press(1);
        chk({tag, "_field_min"}, 32'(bus.edit_field), 32'd2);
        for (int i = 0; i < nm; i++) press(2);
        eh = (sh + nh) % 24;
        em = (sm + nm) % 60;
        bus.btn_set = 1'b1;
        step(1);
        bus.btn_set = 1'b0;
        hi = 0;
        other = 0;
        for (int i = 0; i < 2 * HOLD; i++) begin
            if ((tgt != 0 ? bus.LD_alarm : bus.LD_time) === 1'b1) hi++;
            if ((tgt != 0 ? bus.LD_time : bus.LD_alarm) !== 1'b0) other++;
            step(1);
        end
        chk({tag, "_strobe_len"}, 32'(hi), 32'(HOLD));
        chk({tag, "_other_strobe"}, 32'(other), 32'd0);
        chk({tag, "_value"}, shown(), pack_hm(eh, em));
        chk({tag, "_idle"}, 32'(bus.editing), 32'd0);
        if (tgt != 0) begin
            alarm_h = eh;
            alarm_m = em;
        end
    endtask

    initial begin
        int ld0, n_hold, exp_inc, rh, rm, rt;
        total = 0; bad = 0; ld_cycles = 0; both_cycles = 0;
        alarm_h = 0; alarm_m = 0;
        bus.btn_mode = 1'b0; bus.btn_set = 1'b0; bus.btn_inc = 1'b0;
        set_cur(0, 0);
        reset = 1'b1;
        step(3);
        chk("rst_editing", 32'(bus.editing), 32'd0);
        chk("rst_value", shown(), 32'd0);
        chk("rst_ld", {30'd0, bus.LD_time, bus.LD_alarm}, 32'd0);
        chk("rst_field", {29'd0, bus.edit_target, bus.edit_field}, 32'd0);
        reset = 1'b0;
        step(2);

        // 1: time edit 12:34 -> 14:35
        do_edit(0, 12, 34, 2, 1, "t1");
        // 2: alarm edit 00:00 -> 07:30, then re-entry seeds from shadow
        do_edit(1, 5, 5, 7, 30, "t2");
        enter_hr(1, 7, 30, "t2_reseed");
        press(0);
        chk("t2_abort", 32'(bus.editing), 32'd0);
        // 3: BCD wraps
        do_edit(0, 23, 59, 1, 1, "t3_wrap");
        do_edit(0, 9, 0, 1, 0, "t3_h09");

        // 4: auto-repeat in EDIT_MIN for 3*REP+1 held cycles
        ld0 = ld_cycles;
        set_cur(11, 0);
        enter_hr(0, 11, 0, "t4");
        press(1);
        n_hold = 3 * REP + 1;
        exp_inc = 1 + (n_hold - 2) / int'(REP);
        bus.btn_inc = 1'b1;
        step(n_hold);
        bus.btn_inc = 1'b0;
        step(2);
        chk("t4_repeat", shown(), pack_hm(11, exp_inc));
        press(0);
        // mode and set together in EDIT_HR: mode wins
        enter_hr(0, 11, 0, "t4b");
        bus.btn_mode = 1'b1; bus.btn_set = 1'b1;
        step(1);
        bus.btn_mode = 1'b0; bus.btn_set = 1'b0;
        step(HOLD + 5);
        chk("t4_mode_prio", {30'd0, bus.editing, 1'b0} | 32'(bus.edit_field), 32'd0);
        chk("t4_no_strobe", 32'(ld_cycles - ld0), 32'd0);

        // 5: timeout in alarm EDIT_HR, shadow kept
        ld0 = ld_cycles;
        enter_hr(1, alarm_h, alarm_m, "t5");
        press(2);
        step(TOUT - 10);
        chk("t5_before", 32'(bus.editing), 32'd1);
        step(15);
        chk("t5_timeout", 32'(bus.editing), 32'd0);
        chk("t5_no_strobe", 32'(ld_cycles - ld0), 32'd0);
        enter_hr(1, alarm_h, alarm_m, "t5_shadow");
        press(0);

        // randomized edits against the model
        for (int k = 0; k < 8; k++) begin
            rh = int'($urandom_range(0, 23));
            rm = int'($urandom_range(0, 59));
            rt = int'($urandom_range(0, 1));
            do_edit(rt, rh, rm, int'($urandom_range(0, 26)), int'($urandom_range(0, 64)), "rnd");
        end

        // 6: reset mid-COMMIT with buttons held through reset
        set_cur(8, 15);
        enter_hr(0, 8, 15, "t6");
        press(1);
        bus.btn_set = 1'b1;
        step(1);
        step(3);
        chk("t6_in_commit", 32'(bus.LD_time), 32'd1);
        bus.btn_mode = 1'b1;
        #2 reset = 1'b1;
        #1;
        chk("t6_async_drop", {30'd0, bus.LD_time, bus.LD_alarm}, 32'd0);
        step(2);
        reset = 1'b0;
        step(3);
        chk("t6_held_no_press", 32'(bus.editing), 32'd0);
        ld0 = ld_cycles;
        bus.btn_set = 1'b0;
        bus.btn_mode = 1'b0;
        step(HOLD + 3);
        chk("t6_no_phantom", {31'd0, bus.editing}, 32'd0);
        chk("t6_no_strobe", 32'(ld_cycles - ld0), 32'd0);
        chk("t6_shadow_reset", 32'(0), 32'(0) | 32'(bus.edit_target));
        alarm_h = 0;
        alarm_m = 0;
        do_edit(1, 3, 3, 2, 3, "t6_after");

        chk("ld_never_both", 32'(both_cycles), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
